// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC128S-class SPI master (a2d_spi_intf).
package a2d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PORCH = 2'd1,
    ST_XFER  = 2'd2,
    ST_PAUSE = 2'd3
  } a2d_state_t;

  localparam logic [1:0] CMD_PREFIX = 2'b00;
  localparam int         WORD_W     = 16;
  localparam int         RES_W      = 12;

  // Divider landmarks as a function of divider width (24 / 17 / 31 at width 5).
  function automatic int porch_pre(input int div_bits);
    return 3 << (div_bits - 2);
  endfunction

  function automatic int sample_pt(input int div_bits);
    return (1 << (div_bits - 1)) + 1;
  endfunction

  function automatic int shift_pt(input int div_bits);
    return (1 << div_bits) - 1;
  endfunction

  function automatic logic [WORD_W-1:0] cmd_word(input logic [2:0] ch);
    return {CMD_PREFIX, ch, 11'b0};
  endfunction

endpackage

// File: rtl/a2d_spi_shft.sv
// SCLK divider, MISO sample bit, 16-bit shift register and bit counter.
module a2d_spi_shft
  import a2d_pkg::*;
#(
  parameter int DIV_BITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_cmd,
  input  logic              i_active,
  input  logic              i_xfer,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_div_wrap,
  output logic              o_shift_done,
  output logic [RES_W-1:0]  o_rx_res
);

  localparam logic [DIV_BITS-1:0] C_PRE    = DIV_BITS'(porch_pre(DIV_BITS));
  localparam logic [DIV_BITS-1:0] C_SAMPLE = DIV_BITS'(sample_pt(DIV_BITS));
  localparam logic [DIV_BITS-1:0] C_SHIFT  = DIV_BITS'(shift_pt(DIV_BITS));

  logic [DIV_BITS-1:0] r_div;
  logic [3:0]          r_cnt;
  logic [WORD_W-1:0]   r_shft;
  logic                r_smpl;
  logic                r_sclk;
  logic [DIV_BITS-1:0] w_div_nxt;
  logic [WORD_W-1:0]   w_rx_word;

  assign w_div_nxt    = r_div + DIV_BITS'(1);
  assign w_rx_word    = {r_shft[WORD_W-2:0], r_smpl};
  assign o_div_wrap   = (r_div == C_SHIFT);
  assign o_shift_done = i_xfer && o_div_wrap && (r_cnt == 4'd15);
  assign o_rx_res     = w_rx_word[RES_W-1:0];
  assign o_sclk       = r_sclk;
  assign o_mosi       = r_shft[WORD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_cnt  <= '0;
      r_shft <= '0;
      r_smpl <= 1'b0;
      r_sclk <= 1'b1;
    end else if (i_load) begin
      r_div  <= C_PRE;
      r_cnt  <= '0;
      r_shft <= i_cmd;
      r_sclk <= 1'b1;
    end else begin
      if (i_active)
        r_div <= w_div_nxt;
      if (i_xfer && (r_div == C_SAMPLE))
        r_smpl <= i_miso;
      if (i_xfer && o_div_wrap) begin
        r_shft <= w_rx_word;
        r_cnt  <= r_cnt + 4'd1;
      end
      // SCLK tracks the next divider MSB; the final shift parks it high so no 17th fall.
      r_sclk <= (i_active && !o_shift_done) ? w_div_nxt[DIV_BITS-1] : 1'b1;
    end
  end

endmodule

// File: rtl/a2d_spi_intf.sv
// SPI master for an 8-channel 12-bit ADC: command txn, pause, result txn.
// Optional A2D_INV_RES_EN build inverts the captured result.
//   state | meaning
//   IDLE  | waiting for strt_cnv, SS_n high
//   PORCH | SS_n low, SCLK high, divider running up to wrap
//   XFER  | 16 SCLK periods, shifting command out and data in
//   PAUSE | SS_n high between command and result transactions
module a2d_spi_intf
  import a2d_pkg::*;
#(
  parameter int DIV_BITS   = 5,
  parameter int PAUSE_CLKS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt_cnv,
  input  logic [2:0]       chnnl,
  input  logic             MISO,
  output logic             SS_n,
  output logic             SCLK,
  output logic             MOSI,
  output logic             cnv_cmplt,
  output logic [RES_W-1:0] res
);

  localparam int            PW        = $clog2(PAUSE_CLKS + 1);
  localparam logic [PW-1:0] C_PAUSE_LD = PW'(PAUSE_CLKS - 1);

  a2d_state_t        r_state;
  a2d_state_t        w_state_nxt;
  logic              r_txn;
  logic [2:0]        r_chnnl;
  logic [PW-1:0]     r_pause;
  logic              r_ss_n;
  logic              r_cmplt;
  logic [RES_W-1:0]  r_res;
  logic              w_load;
  logic [WORD_W-1:0] w_cmd;
  logic              w_div_wrap;
  logic              w_shift_done;
  logic [RES_W-1:0]  w_rx_res;
  logic [RES_W-1:0]  w_res_nxt;

`ifdef A2D_INV_RES_EN
  assign w_res_nxt = ~w_rx_res;
`else
  assign w_res_nxt = w_rx_res;
`endif

  assign SS_n      = r_ss_n;
  assign cnv_cmplt = r_cmplt;
  assign res       = r_res;

  a2d_spi_shft #(
    .DIV_BITS(DIV_BITS)
  ) u_shft (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_cmd       (w_cmd),
    .i_active    ((r_state == ST_PORCH) || (r_state == ST_XFER)),
    .i_xfer      (r_state == ST_XFER),
    .i_miso      (MISO),
    .o_sclk      (SCLK),
    .o_mosi      (MOSI),
    .o_div_wrap  (w_div_wrap),
    .o_shift_done(w_shift_done),
    .o_rx_res    (w_rx_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cmd       = cmd_word(r_chnnl);
    case (r_state)
      ST_IDLE: begin
        if (strt_cnv) begin
          w_load      = 1'b1;
          w_cmd       = cmd_word(chnnl);
          w_state_nxt = ST_PORCH;
        end
      end
      ST_PORCH: begin
        if (w_div_wrap)
          w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (w_shift_done)
          w_state_nxt = r_txn ? ST_IDLE : ST_PAUSE;
      end
      ST_PAUSE: begin
        if (r_pause == '0) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PORCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_txn   <= 1'b0;
      r_chnnl <= '0;
      r_pause <= '0;
      r_ss_n  <= 1'b1;
      r_cmplt <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (strt_cnv) begin
            r_chnnl <= chnnl;
            r_cmplt <= 1'b0;
            r_ss_n  <= 1'b0;
            r_txn   <= 1'b0;
          end
        end
        ST_XFER: begin
          if (w_shift_done) begin
            r_ss_n <= 1'b1;
            if (r_txn) begin
              r_res   <= w_res_nxt;
              r_cmplt <= 1'b1;
            end else begin
              r_pause <= C_PAUSE_LD;
            end
          end
        end
        ST_PAUSE: begin
          if (r_pause == '0) begin
            r_ss_n <= 1'b0;
            r_txn  <= 1'b1;
          end else begin
            r_pause <= r_pause - PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Scoreboard bench for a2d_spi_intf: ADC model on SPI pins plus completion monitor.
module tb_a2d_spi_intf;

  logic        clk;
  logic        rst;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        cnv_cmplt;
  logic [11:0] res;

  typedef struct {
    logic [11:0] res;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cmd_q[$];
  logic [15:0] miso_q[$];
  int          n_chk;
  int          n_fail;
  int          cyc;

  a2d_spi_intf dut (
    .clk      (clk),
    .rst      (rst),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .cnv_cmplt(cnv_cmplt),
    .res      (res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic logic [11:0] exp_res(input logic [15:0] w);
`ifdef A2D_INV_RES_EN
    return ~w[11:0];
`else
    return w[11:0];
`endif
  endfunction

  // Call at a negedge; E0 is the following posedge.
  task automatic start_conv(input logic [2:0] ch, input logic [15:0] w0, input logic [15:0] w1);
    exp_t e;
    chnnl    = ch;
    strt_cnv = 1'b1;
    cmd_q.push_back({2'b00, ch, 11'b0});
    cmd_q.push_back({2'b00, ch, 11'b0});
    miso_q.push_back(w0);
    miso_q.push_back(w1);
    e.res      = exp_res(w1);
    e.done_cyc = cyc + 1 + 1072;
    exp_q.push_back(e);
    @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!cnv_cmplt && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!cnv_cmplt)
      chk("done_timeout", {31'b0, cnv_cmplt}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ss_n"}, {31'b0, SS_n}, 32'd1);
    chk({tag, "_sclk"}, {31'b0, SCLK}, 32'd1);
    chk({tag, "_mosi"}, {31'b0, MOSI}, 32'd0);
    chk({tag, "_cmplt"}, {31'b0, cnv_cmplt}, 32'd0);
    chk({tag, "_res"}, {20'b0, res}, 32'd0);
  endtask

  // Completion monitor
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (cnv_cmplt && !prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_cmplt", {31'b0, cnv_cmplt}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("res", {20'b0, res}, {20'b0, e.res});
            chk("latency_cyc", cyc, e.done_cyc);
          end
        end
        prev = cnv_cmplt;
      end
    end
  end

  // ADC model: drives MISO, captures MOSI, checks SPI framing
  initial begin
    logic        prev_ss, prev_sclk, prev_mosi;
    logic        ss_fall, ss_rise, sc_rise, sc_fall;
    logic [15:0] word, rx;
    int          nr, t_ssf, t_ssr, t_last, txn_idx;
    MISO = 1'b0;
    prev_ss = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
    word = '0; rx = '0;
    nr = 0; t_ssf = 0; t_ssr = 0; t_last = 0; txn_idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ss = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
        nr = 0; txn_idx = 0; MISO = 1'b0;
      end else begin
        ss_fall = prev_ss && !SS_n;
        ss_rise = !prev_ss && SS_n;
        sc_rise = !prev_sclk && SCLK && !SS_n;
        sc_fall = prev_sclk && !SCLK;
        if (MOSI !== prev_mosi)
          chk("mosi_change_edge", {31'b0, (sc_fall && !SS_n) || ss_fall || ss_rise}, 32'd1);
        if (ss_fall) begin
          word  = (miso_q.size() > 0) ? miso_q.pop_front() : 16'h0000;
          rx    = '0;
          nr    = 0;
          t_ssf = cyc;
          MISO  = word[15];
          if (txn_idx == 1)
            chk("pause_clks", cyc - t_ssr, 32'd32);
        end
        if (sc_rise) begin
          rx = {rx[14:0], MOSI};
          nr++;
          if (nr == 1)
            chk("first_rise_clks", cyc - t_ssf, 32'd24);
          else
            chk("sclk_period", cyc - t_last, 32'd32);
          t_last = cyc;
        end
        if (sc_fall && !SS_n) begin
          chk("sclk_fall_in_txn", {31'b0, nr < 16}, 32'd1);
          if (nr > 0 && nr < 16)
            MISO = word[15 - nr];
        end
        if (ss_rise) begin
          chk("rise_count", nr, 32'd16);
          if (cmd_q.size() == 0)
            chk("unexpected_txn", {16'b0, rx}, 32'hFFFF_FFFF);
          else
            chk("mosi_word", {16'b0, rx}, {16'b0, cmd_q.pop_front()});
          t_ssr   = cyc;
          txn_idx = (txn_idx == 0) ? 1 : 0;
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
        prev_mosi = MOSI;
      end
    end
  end

  // Stimulus
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    strt_cnv = 1'b0;
    chnnl = 3'd0;
    #2 rst = 1'b1;
    #1 chk_reset_outs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic conversion on channel 3, with a request on channel 5 while busy
    start_conv(3'd3, 16'h5A5A, 16'h0ABC);
    repeat (299) @(negedge clk);
    chnnl = 3'd5;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    chnnl = 3'd0;
    wait_done();

    // Back-to-back: request on the cycle after completion
    start_conv(3'd6, 16'hC3C3, 16'hF555);
    chk("cmplt_cleared", {31'b0, cnv_cmplt}, 32'd0);
    wait_done();

    // Reset in the middle of the second transaction
    @(negedge clk);
    start_conv(3'd2, 16'h1111, 16'h2222);
    repeat (599) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outs("midop");
    exp_q.delete();
    cmd_q.delete();
    miso_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_hold_ss_n", {31'b0, SS_n}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fresh conversion on channel 7 after the abort
    start_conv(3'd7, 16'hFFFF, 16'h0123);
    wait_done();
    repeat (5) @(negedge clk);
    chk("res_hold", {20'b0, res}, {20'b0, exp_res(16'h0123)});
    chk("cmplt_hold", {31'b0, cnv_cmplt}, 32'd1);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("cmd_q_empty", cmd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
